nn_layer_engine: RTL and testbench
==================================

Name: nn_layer_engine

Overview:
Parametrised, time-multiplexed perceptron layer for the TinyTapeout neural-network design.
- Holds weights, biases and thresholds for N_NEUR neurons of N_IN inputs each, loaded byte-serially.
- Evaluates the whole layer with one shared multiply-accumulate unit, driven by a sequencer FSM.
- Exposes per-neuron results through a select mux.
- Adds a selectable activation (step or saturated ReLU) and on-chip recirculation of outputs into inputs for multi-layer runs.

Parameters:
- N_IN, 4, inputs per neuron (≥1).
- N_NEUR, 4, number of neurons (≥1); recirculation legal only when N_NEUR==N_IN.
- DW, 8, data/parameter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable. When 0, every register holds.
- cfg_valid  in  1  parameter byte strobe.
- cfg_data  in  DW  parameter byte (signed two's complement).
- in_valid  in  1  input sample strobe.
- in_data  in  DW  input sample (unsigned).
- in_ready  out  1  high in IDLE; low otherwise.
- act_mode  in  1  0=step, 1=saturated ReLU. Sampled when compute starts.
- recirc  in  1  in IDLE: copy results to inputs and start compute.
- busy  out  1  high during compute and DONE.
- done  out  1  one-cycle pulse when results are valid.
- cfg_full  out  1  high once a complete parameter set has been written.
- out_sel  in  clog2(N_NEUR)  result select.
- out_data  out  DW  result[out_sel], combinational mux of registered results. Out-of-range select returns 0.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All parameter, input and result registers, accumulator and pointers are 0.
  - busy=0, done=0, cfg_full=0, in_ready=1, out_data=0.
- Parameter load (IDLE only):
  - Each cfg_valid writes slot cfg_ptr, then cfg_ptr increments.
  - Slot order per neuron n: w[n][0..N_IN-1], bias[n], th[n]. Total N_NEUR*(N_IN+2) slots.
  - Writing the last slot sets cfg_full and wraps cfg_ptr to 0. cfg_full stays set until reset.
  - cfg_valid outside IDLE is ignored; the pointer does not move.
- Input load: in_valid while in_ready writes in[in_ptr] and increments in_ptr.
  - Accepting in[N_IN-1] wraps in_ptr to 0, latches act_mode and enters COMPUTE on the same edge.
  - If cfg_valid and in_valid arrive in the same cycle, both are accepted.
- recirc in IDLE with in_ptr==0:
  - Copies result[k] to in[k] and enters COMPUTE.
  - Ignored if N_NEUR!=N_IN or in_ptr!=0.
  - in_valid has priority over recirc in the same cycle.
- FSM states: IDLE, COMPUTE, FINAL, DONE.
  - COMPUTE: acc += in[i]*w[n][i], with in zero-extended and w sign-extended. i increments each cycle; i==N_IN-1 goes to FINAL.
  - FINAL: s = acc + bias[n].
    - Step mode: result[n] = (s ≥ th[n]) ? 1 : 0.
    - ReLU mode: result[n] = clamp(s − th[n], 0, 2^DW−1).
    - Then acc clears and i resets to 0. If n<N_NEUR−1, n increments and the FSM returns to COMPUTE; otherwise it goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Latency: done is high exactly N_NEUR*(N_IN+1)+1 cycles after the accept edge (21 with defaults). Results are stable from that cycle until the next FINAL.
- Arithmetic width: ACC_W = 2*DW+clog2(N_IN)+2 bits signed, so no overflow is possible. The ReLU clamp is computed at ACC_W.
- Result updates: result[n] changes only in FINAL. Results of an interrupted run keep old values for neurons not yet finalised.
- Reset mid-compute: immediate abort to the reset state; parameters are lost.
- ena=0 mid-compute: the sequence pauses. On resuming it continues with identical results; latency stretches by the paused cycles.

Decomposition:
- Package nn_pkg: ACC_W function, state enum, slot-index function slot(n,k)=n*(N_IN+2)+k.
- One sub-module nn_mac_unit: a combinational signed multiply, plus the accumulator register with clear and enable.
- FSM, parameter register file and result mux stay in nn_layer_engine.

Test Plan:
1. Reset -> busy=0, done=0, in_ready=1, cfg_full=0, out_data=0 for every out_sel.
2. Step mode, all w=1, bias=0, th=10; inputs 1,2,3,4:
   - Every result is 1; done at cycle 21 after accept.
   - Repeat with th=11 -> every result is 0.
3. ReLU mode with inputs 100,50,0,0:
   - n0: w=2,0xFF,0,0, b=5, th=3 -> result 152.
   - n1: w=3,3,3,3, b=0, th=0 -> result 255 (saturated).
   - n2: w=0xFF,0,0,0 -> result 0.
4. cfg_valid and in_valid pulsed while busy -> ignored:
   - Parameters unchanged, in_ptr unchanged, results identical to the undisturbed run.
   - cfg_full asserts exactly after write 24.
5. rst_n low on compute cycle 7 -> busy drops immediately and all results read 0. ena low for 5 cycles mid-run -> done arrives at cycle 26 with correct values.
6. After test 2 (step mode, results all 1), pulse recirc -> inputs become 1,1,1,1; with th=10 the new results are all 0. recirc while in_ptr=2 -> ignored.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and helpers for the time-multiplexed perceptron layer.
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_FINAL   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Accumulator width: full product plus growth over N_IN terms, bias and threshold.
    function automatic int unsigned acc_w(input int unsigned dw, input int unsigned n_in);
        return 2 * dw + $clog2(n_in) + 2;
    endfunction

    // Parameter slot index: neuron n holds w[0..n_in-1], bias, threshold.
    function automatic int unsigned slot(input int unsigned n, input int unsigned k,
                                         input int unsigned n_in);
        return n * (n_in + 2) + k;
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Shared multiply-accumulate: unsigned sample times signed weight into a signed accumulator.
module nn_mac_unit
    import nn_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned ACC_W = acc_w(8, 4)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic                    i_clr,
    input  logic                    i_acc,
    input  logic [DW-1:0]           i_a,
    input  logic [DW-1:0]           i_b,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [ACC_W-1:0] w_a;
    logic signed [ACC_W-1:0] w_b;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] r_acc;

    assign w_a    = {{(ACC_W-DW){1'b0}}, i_a};
    assign w_b    = {{(ACC_W-DW){i_b[DW-1]}}, i_b};
    assign w_prod = w_a * w_b;
    assign o_acc  = r_acc;

    // Accumulator: clear wins over accumulate; everything holds while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_acc) begin
                r_acc <= r_acc + w_prod;
            end
        end
    end

endmodule

// File: rtl/nn_layer_engine.sv
// Perceptron layer: serial parameter load, sequenced shared MAC, step/ReLU activation, recirculation.
module nn_layer_engine
    import nn_pkg::*;
#(
    parameter  int unsigned N_IN   = 4,
    parameter  int unsigned N_NEUR = 4,
    parameter  int unsigned DW     = 8,
    localparam int unsigned SEL_W  = (N_NEUR > 1) ? $clog2(N_NEUR) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cfg_valid,
    input  logic [DW-1:0]    cfg_data,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    input  logic             act_mode,
    input  logic             recirc,
    output logic             busy,
    output logic             done,
    output logic             cfg_full,
    input  logic [SEL_W-1:0] out_sel,
    output logic [DW-1:0]    out_data
);

    localparam int unsigned ACC_W     = acc_w(DW, N_IN);
    localparam int unsigned N_SLOT    = N_NEUR * (N_IN + 2);
    localparam int unsigned CPW       = $clog2(N_SLOT);
    localparam int unsigned IPW       = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned N_CP      = (N_IN < N_NEUR) ? N_IN : N_NEUR;
    localparam bit          RECIRC_OK = (N_IN == N_NEUR);
    localparam logic signed [ACC_W-1:0] RES_MAX = {{(ACC_W-DW){1'b0}}, {DW{1'b1}}};

    state_t             r_state;
    logic [DW-1:0]      r_cfg [N_SLOT];
    logic [DW-1:0]      r_in  [N_IN];
    logic [DW-1:0]      r_res [N_NEUR];
    logic [CPW-1:0]     r_cfg_ptr;
    logic [IPW-1:0]     r_in_ptr;
    logic [IPW-1:0]     r_i;
    logic [SEL_W-1:0]   r_n;
    logic               r_act_mode;
    logic               r_cfg_full;
    logic               r_busy;
    logic               r_done;
    logic               r_in_ready;

    logic [CPW-1:0]          w_w_idx;
    logic [CPW-1:0]          w_b_idx;
    logic [CPW-1:0]          w_t_idx;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_bias_x;
    logic signed [ACC_W-1:0] w_th_x;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_diff;
    logic [DW-1:0]           w_res_new;
    logic [DW-1:0]           w_res_pad [2**SEL_W];

    assign w_w_idx  = CPW'(slot(32'(r_n), 32'(r_i), N_IN));
    assign w_b_idx  = CPW'(slot(32'(r_n), N_IN, N_IN));
    assign w_t_idx  = CPW'(slot(32'(r_n), N_IN + 1, N_IN));
    assign w_bias_x = {{(ACC_W-DW){r_cfg[w_b_idx][DW-1]}}, r_cfg[w_b_idx]};
    assign w_th_x   = {{(ACC_W-DW){r_cfg[w_t_idx][DW-1]}}, r_cfg[w_t_idx]};
    assign w_sum    = w_acc + w_bias_x;
    assign w_diff   = w_sum - w_th_x;

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign cfg_full = r_cfg_full;

    nn_mac_unit #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (ena),
        .i_clr (r_state == ST_FINAL),
        .i_acc (r_state == ST_COMPUTE),
        .i_a   (r_in[r_i]),
        .i_b   (r_cfg[w_w_idx]),
        .o_acc (w_acc)
    );

    // Activation of the neuron being finalised; clamp evaluated at full accumulator width.
    always_comb begin
        w_res_new = '0;
        if (!r_act_mode) begin
            if (w_sum >= w_th_x) w_res_new = DW'(1);
        end else if (w_diff[ACC_W-1]) begin
            w_res_new = '0;
        end else if (w_diff > RES_MAX) begin
            w_res_new = '1;
        end else begin
            w_res_new = w_diff[DW-1:0];
        end
    end

    // Result select: unused select codes read back as zero.
    always_comb begin
        for (int k = 0; k < 2**SEL_W; k++) w_res_pad[k] = '0;
        for (int k = 0; k < N_NEUR; k++)   w_res_pad[k] = r_res[k];
    end

    assign out_data = w_res_pad[out_sel];

    // Sequencer, parameter/input/result storage and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cfg_ptr  <= '0;
            r_in_ptr   <= '0;
            r_i        <= '0;
            r_n        <= '0;
            r_act_mode <= 1'b0;
            r_cfg_full <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_in_ready <= 1'b1;
            for (int k = 0; k < N_SLOT; k++) r_cfg[k] <= '0;
            for (int k = 0; k < N_IN; k++)   r_in[k]  <= '0;
            for (int k = 0; k < N_NEUR; k++) r_res[k] <= '0;
        end else if (ena) begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        r_cfg[r_cfg_ptr] <= cfg_data;
                        if (r_cfg_ptr == CPW'(N_SLOT - 1)) begin
                            r_cfg_ptr  <= '0;
                            r_cfg_full <= 1'b1;
                        end else begin
                            r_cfg_ptr <= r_cfg_ptr + CPW'(1);
                        end
                    end
                    if (in_valid) begin
                        r_in[r_in_ptr] <= in_data;
                        if (r_in_ptr == IPW'(N_IN - 1)) begin
                            r_in_ptr   <= '0;
                            r_act_mode <= act_mode;
                            r_i        <= '0;
                            r_n        <= '0;
                            r_busy     <= 1'b1;
                            r_in_ready <= 1'b0;
                            r_state    <= ST_COMPUTE;
                        end else begin
                            r_in_ptr <= r_in_ptr + IPW'(1);
                        end
                    end else if (recirc && RECIRC_OK && (r_in_ptr == '0)) begin
                        for (int k = 0; k < N_CP; k++) r_in[k] <= r_res[k];
                        r_act_mode <= act_mode;
                        r_i        <= '0;
                        r_n        <= '0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (r_i == IPW'(N_IN - 1)) begin
                        r_state <= ST_FINAL;
                    end else begin
                        r_i <= r_i + IPW'(1);
                    end
                end
                ST_FINAL: begin
                    r_res[r_n] <= w_res_new;
                    r_i        <= '0;
                    if (r_n == SEL_W'(N_NEUR - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_n     <= r_n + SEL_W'(1);
                        r_state <= ST_COMPUTE;
                    end
                end
                ST_DONE: begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_engine.sv
// Directed bench for nn_layer_engine with hand-computed expected results.
module tb_nn_layer_engine;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       ena       = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data  = '0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = '0;
    logic       act_mode  = 1'b0;
    logic       recirc    = 1'b0;
    logic [1:0] out_sel   = '0;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       cfg_full;
    logic [7:0] out_data;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] p [24];

    always #5 clk = ~clk;

    nn_layer_engine #(.N_IN(4), .N_NEUR(4), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .act_mode  (act_mode),
        .recirc    (recirc),
        .busy      (busy),
        .done      (done),
        .cfg_full  (cfg_full),
        .out_sel   (out_sel),
        .out_data  (out_data)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_neuron(input int n, input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3,
                              input logic [7:0] b, input logic [7:0] th);
        p[n*6+0] = w0; p[n*6+1] = w1; p[n*6+2] = w2; p[n*6+3] = w3;
        p[n*6+4] = b;  p[n*6+5] = th;
    endtask

    task automatic load_params(input bit chk_full);
        for (int s = 0; s < 24; s++) begin
            cfg_valid = 1'b1;
            cfg_data  = p[s];
            tick();
            if (chk_full && s == 22) check_val("cfg_full after 23 writes", cfg_full, 0);
            if (chk_full && s == 23) check_val("cfg_full after 24 writes", cfg_full, 1);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic send_one(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_inputs(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d, input logic mode);
        act_mode = mode;
        send_one(a); send_one(b); send_one(c); send_one(d);
    endtask

    // Counts cycles from the start edge until done; optional ena pause and busy-time strobes.
    task automatic wait_done(input string tag, input int exp_lat, input int pause_at,
                             input bit disturb);
        int cyc = 0;
        while (cyc < 200) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                check_val({tag, " busy"}, busy, 1);
                check_val({tag, " in_ready"}, in_ready, 0);
            end
            if (done) break;
            if (pause_at >= 0 && cyc == pause_at)     ena = 1'b0;
            if (pause_at >= 0 && cyc == pause_at + 5) ena = 1'b1;
            if (disturb && cyc == 2) begin
                cfg_valid = 1'b1; cfg_data = 8'h7F;
                in_valid  = 1'b1; in_data  = 8'h55;
            end
            if (disturb && cyc == 6) begin
                cfg_valid = 1'b0;
                in_valid  = 1'b0;
            end
        end
        ena = 1'b1; cfg_valid = 1'b0; in_valid = 1'b0;
        check_val({tag, " latency"}, cyc, exp_lat);
        tick();
        check_val({tag, " done pulse width"}, done, 0);
    endtask

    task automatic check_results(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                                 input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 4; k++) begin
            out_sel = 2'(k);
            #1;
            check_val($sformatf("%s result%0d", tag, k), out_data, e[k]);
        end
    endtask

    task automatic load_relu_set();
        set_neuron(0, 8'd2, 8'hFF, 8'd0, 8'd0, 8'd5, 8'd3);
        set_neuron(1, 8'd3, 8'd3, 8'd3, 8'd3, 8'd0, 8'd0);
        set_neuron(2, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        set_neuron(3, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0);
        load_params(1'b0);
    endtask

    initial begin
        // Reset state
        #12;
        check_val("reset busy", busy, 0);
        check_val("reset done", done, 0);
        check_val("reset in_ready", in_ready, 1);
        check_val("reset cfg_full", cfg_full, 0);
        check_results("reset", 8'd0, 8'd0, 8'd0, 8'd0);
        #2 rst_n = 1'b1;
        tick();

        // Step mode, threshold reached exactly
        for (int n = 0; n < 4; n++) set_neuron(n, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd10);
        load_params(1'b1);
        send_inputs(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        wait_done("step th10", 21, -1, 1'b0);
        check_results("step th10", 8'd1, 8'd1, 8'd1, 8'd1);

        // Step mode, threshold just missed
        for (int n = 0; n < 4; n++) set_neuron(n, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd11);
        load_params(1'b0);
        check_val("cfg_full sticky", cfg_full, 1);
        send_inputs(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        wait_done("step th11", 21, -1, 1'b0);
        check_results("step th11", 8'd0, 8'd0, 8'd0, 8'd0);

        // Recirculation of all-one results into the inputs
        for (int n = 0; n < 4; n++) set_neuron(n, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd10);
        load_params(1'b0);
        send_inputs(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        wait_done("pre-recirc", 21, -1, 1'b0);
        check_results("pre-recirc", 8'd1, 8'd1, 8'd1, 8'd1);
        act_mode = 1'b0;
        recirc   = 1'b1;
        tick();
        recirc   = 1'b0;
        wait_done("recirc", 21, -1, 1'b0);
        check_results("recirc", 8'd0, 8'd0, 8'd0, 8'd0);

        // Recirc with a partially loaded input vector is ignored
        send_one(8'd1);
        send_one(8'd2);
        recirc = 1'b1;
        tick();
        recirc = 1'b0;
        check_val("recirc mid-load busy", busy, 0);
        check_val("recirc mid-load in_ready", in_ready, 1);
        tick();
        check_val("recirc mid-load busy later", busy, 0);
        send_one(8'd3);
        send_one(8'd4);
        wait_done("after ignored recirc", 21, -1, 1'b0);
        check_results("after ignored recirc", 8'd1, 8'd1, 8'd1, 8'd1);

        // ReLU mode with saturation and negative clamp
        load_relu_set();
        send_inputs(8'd100, 8'd50, 8'd0, 8'd0, 1'b1);
        wait_done("relu", 21, -1, 1'b0);
        check_results("relu", 8'd152, 8'd255, 8'd0, 8'd150);

        // Strobes while busy are ignored; a follow-up run exposes any corruption
        send_inputs(8'd100, 8'd50, 8'd0, 8'd0, 1'b1);
        wait_done("relu disturbed", 21, -1, 1'b1);
        check_results("relu disturbed", 8'd152, 8'd255, 8'd0, 8'd150);
        send_inputs(8'd100, 8'd50, 8'd0, 8'd0, 1'b1);
        wait_done("relu after disturb", 21, -1, 1'b0);
        check_results("relu after disturb", 8'd152, 8'd255, 8'd0, 8'd150);

        // Asynchronous reset on compute cycle 7
        send_inputs(8'd100, 8'd50, 8'd0, 8'd0, 1'b1);
        for (int c = 0; c < 7; c++) tick();
        rst_n = 1'b0;
        #1;
        check_val("mid reset busy", busy, 0);
        check_val("mid reset in_ready", in_ready, 1);
        check_val("mid reset cfg_full", cfg_full, 0);
        check_results("mid reset", 8'd0, 8'd0, 8'd0, 8'd0);
        rst_n = 1'b1;
        tick();

        // Enable pause stretches latency by the paused cycles
        load_relu_set();
        send_inputs(8'd100, 8'd50, 8'd0, 8'd0, 1'b1);
        wait_done("ena pause", 26, 3, 1'b0);
        check_results("ena pause", 8'd152, 8'd255, 8'd0, 8'd150);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
